// File: rtl/rainbow_pkg.sv
// rainbow_pkg: shared state encodings, defaults and channel indices for the rainbow sequencer.
package rainbow_pkg;

    typedef enum logic [1:0] {CH_OFF, CH_UP, CH_DOWN} ch_state_t;
    typedef enum logic [1:0] {SQ_IDLE, SQ_LAUNCH, SQ_GAP, SQ_RUN} seq_state_t;

    localparam int DEF_FREQ    = 2400;
    localparam int DEF_CW      = 25;
    localparam int DEF_STAGGER = 2 * DEF_FREQ * DEF_FREQ / 3;

    localparam int R = 0;
    localparam int G = 1;
    localparam int B = 2;

    // Top edge to down->up flip: lands mid-period after duty hits 0, before it would wrap.
    function automatic int bot_dly(input int freq);
        return freq * (freq - 1) + freq / 2;
    endfunction

endpackage

// File: rtl/rainbow_seq_ctrl_if.sv
// rainbow_seq_ctrl_if: enable/monitor inputs and per-channel control outputs of the rainbow sequencer.
interface rainbow_seq_ctrl_if;

    logic       en;
    logic [2:0] stt;
    logic [2:0] flag;
    logic [2:0] active;
    logic [2:0] err;

    modport master (output en, output stt, input flag, input active, input err);
    modport slave  (input en, input stt, output flag, output active, output err);

endinterface

// File: rtl/rainbow_ch_fsm.sv
// rainbow_ch_fsm: one breathing channel's up/down ramp control; RAINBOW_TOP_TIMEOUT_EN adds an UP timeout with sticky err.
module rainbow_ch_fsm
    import rainbow_pkg::*;
#(
    parameter int FREQ = DEF_FREQ,
    parameter int CW   = DEF_CW
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic launch,
    input  logic stt,
    output logic flag,
    output logic active,
    output logic err
);

    localparam logic [CW-1:0] BOT_LAST = CW'(bot_dly(FREQ) - 1);

    ch_state_t     st;
    logic          stt_q;
    logic          top_q;
    logic          up_to;
    logic [CW-1:0] tmr;

`ifdef RAINBOW_TOP_TIMEOUT_EN
    localparam logic [CW-1:0] TOP_LAST = CW'(FREQ * FREQ + FREQ - 1);
    assign up_to = tmr == TOP_LAST;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err <= 1'b0;
        else if (en && st == CH_UP && !top_q && up_to)
            err <= 1'b1;
    end
`else
    assign up_to = 1'b0;
    assign err   = 1'b0;
`endif

    // top_q is masked while OFF so an STT already high at launch never counts as an edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st     <= CH_OFF;
            flag   <= 1'b0;
            active <= 1'b0;
            stt_q  <= 1'b0;
            top_q  <= 1'b0;
            tmr    <= '0;
        end else begin
            stt_q <= stt;
            top_q <= en && st != CH_OFF && stt && !stt_q;
            if (!en) begin
                st     <= CH_OFF;
                flag   <= 1'b0;
                active <= 1'b0;
                tmr    <= '0;
            end else begin
                case (st)
                    CH_OFF: if (launch) begin
                        st     <= CH_UP;
                        flag   <= 1'b1;
                        active <= 1'b1;
                        tmr    <= '0;
                    end
                    CH_UP: if (top_q || up_to) begin
                        st   <= CH_DOWN;
                        flag <= 1'b0;
                        tmr  <= '0;
                    end
`ifdef RAINBOW_TOP_TIMEOUT_EN
                    else begin
                        tmr <= tmr + CW'(1);
                    end
`endif
                    CH_DOWN: if (tmr == BOT_LAST) begin
                        st   <= CH_UP;
                        flag <= 1'b1;
                        tmr  <= '0;
                    end else begin
                        tmr <= tmr + CW'(1);
                    end
                    default: st <= CH_OFF;
                endcase
            end
        end
    end

endmodule

// File: rtl/rainbow_seq_ctrl.sv
// rainbow_seq_ctrl: launches three breathing PWM channels one stagger apart for a rainbow sweep.
// Optional UP timeout per channel under RAINBOW_TOP_TIMEOUT_EN.
module rainbow_seq_ctrl
    import rainbow_pkg::*;
#(
    parameter int FREQ         = DEF_FREQ,
    parameter int STAGGER_CLKS = DEF_STAGGER,
    parameter int CW           = DEF_CW
) (
    input logic                CLK,
    input logic                RST,
    rainbow_seq_ctrl_if.slave  bus
);

    localparam logic [CW-1:0] GAP_LAST = CW'(STAGGER_CLKS - 1);

    if (longint'(FREQ) * FREQ >= (longint'(1) << CW)) begin : g_cw_chk
        $error("CW too narrow for FREQ*FREQ");
    end
    if (STAGGER_CLKS < 1 || longint'(STAGGER_CLKS) >= (longint'(1) << CW)) begin : g_stag_chk
        $error("STAGGER_CLKS out of range");
    end

    seq_state_t    st;
    logic [1:0]    k;
    logic [CW-1:0] gap;
    logic [2:0]    launch;
    logic [2:0]    flag;
    logic [2:0]    active;
    logic [2:0]    err;

    assign launch = st == SQ_LAUNCH ? 3'b001 << k : 3'b000;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st  <= SQ_IDLE;
            k   <= '0;
            gap <= '0;
        end else if (!bus.en) begin
            st  <= SQ_IDLE;
            k   <= '0;
            gap <= '0;
        end else begin
            case (st)
                SQ_IDLE: begin
                    st <= SQ_LAUNCH;
                    k  <= '0;
                end
                SQ_LAUNCH: begin
                    st  <= k == 2'(B) ? SQ_RUN : SQ_GAP;
                    gap <= '0;
                end
                SQ_GAP: if (gap == GAP_LAST) begin
                    st <= SQ_LAUNCH;
                    k  <= k + 2'd1;
                end else begin
                    gap <= gap + CW'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        rainbow_ch_fsm #(.FREQ(FREQ), .CW(CW)) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .en     (bus.en),
            .launch (launch[c]),
            .stt    (bus.stt[c]),
            .flag   (flag[c]),
            .active (active[c]),
            .err    (err[c])
        );
    end

    assign bus.flag   = flag;
    assign bus.active = active;
    assign bus.err    = err;

endmodule

// File: tb/tb_rainbow_seq_ctrl.sv
// tb_rainbow_seq_ctrl: directed checks of launch stagger, ramp turn, pre-high STT, EN drop and reset.
module tb_rainbow_seq_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad = 0;

    rainbow_seq_ctrl_if bus ();

    rainbow_seq_ctrl #(.FREQ(8), .STAGGER_CLKS(40), .CW(12)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Leaves the bench 1 time unit after the n-th following rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // EN low for one clock clears everything; on return EN=1 was applied just after edge t0.
    task automatic restart();
        bus.en = 1'b0;
        step(1);
        bus.en = 1'b1;
    endtask

    task automatic test_reset();
        bus.en  = 1'b0;
        bus.stt = 3'b000;
        RST     = 1'b1;
        step(2);
        total++;
        if (bus.flag !== 3'b000) begin bad++; $display("FAIL reset_flag: got %b want 000", bus.flag); end
        total++;
        if (bus.active !== 3'b000) begin bad++; $display("FAIL reset_active: got %b want 000", bus.active); end
        total++;
        if (bus.err !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", bus.err); end
        RST = 1'b0;
        step(1);
    endtask

    task automatic test_launch_stagger();
        restart();
        step(1);
        total++;
        if (bus.active !== 3'b000) begin bad++; $display("FAIL stagger_t1: got %b want 000", bus.active); end
        step(1);
        total++;
        if (bus.active !== 3'b001) begin bad++; $display("FAIL stagger_act0: got %b want 001", bus.active); end
        total++;
        if (bus.flag !== 3'b001) begin bad++; $display("FAIL stagger_flag0: got %b want 001", bus.flag); end
        step(40);
        total++;
        if (bus.active !== 3'b001) begin bad++; $display("FAIL stagger_t42: got %b want 001", bus.active); end
        step(1);
        total++;
        if (bus.active !== 3'b011) begin bad++; $display("FAIL stagger_act1: got %b want 011", bus.active); end
        total++;
        if (bus.flag[1] !== 1'b1) begin bad++; $display("FAIL stagger_flag1: got %b want 1", bus.flag[1]); end
        step(40);
        total++;
        if (bus.active !== 3'b011) begin bad++; $display("FAIL stagger_t83: got %b want 011", bus.active); end
        step(1);
        total++;
        if (bus.active !== 3'b111) begin bad++; $display("FAIL stagger_act2: got %b want 111", bus.active); end
        total++;
        if (bus.flag[2] !== 1'b1) begin bad++; $display("FAIL stagger_flag2: got %b want 1", bus.flag[2]); end
    endtask

    task automatic test_ramp_turn();
        restart();
        step(5);
        bus.stt[0] = 1'b1;
        step(1);
        total++;
        if (bus.flag[0] !== 1'b1) begin bad++; $display("FAIL turn_t1p1: got %b want 1", bus.flag[0]); end
        step(1);
        total++;
        if (bus.flag[0] !== 1'b0) begin bad++; $display("FAIL turn_fall: got %b want 0", bus.flag[0]); end
        step(6);
        bus.stt[0] = 1'b0;
        step(12);
        bus.stt[0] = 1'b1;
        step(4);
        bus.stt[0] = 1'b0;
        step(37);
        total++;
        if (bus.flag[0] !== 1'b0) begin bad++; $display("FAIL turn_t61: got %b want 0", bus.flag[0]); end
        total++;
        if (bus.active[0] !== 1'b1) begin bad++; $display("FAIL turn_active: got %b want 1", bus.active[0]); end
        step(1);
        total++;
        if (bus.flag[0] !== 1'b1) begin bad++; $display("FAIL turn_rise: got %b want 1", bus.flag[0]); end
        step(5);
        total++;
        if (bus.flag[0] !== 1'b1) begin bad++; $display("FAIL turn_hold_up: got %b want 1", bus.flag[0]); end
    endtask

    task automatic test_prehigh();
        restart();
        step(20);
        bus.stt[1] = 1'b1;
        step(23);
        total++;
        if (bus.active[1] !== 1'b1 || bus.flag[1] !== 1'b1) begin
            bad++; $display("FAIL prehigh_launch: got act=%b flag=%b want 1 1", bus.active[1], bus.flag[1]);
        end
        step(10);
        total++;
        if (bus.flag[1] !== 1'b1) begin bad++; $display("FAIL prehigh_stay_up: got %b want 1", bus.flag[1]); end
        bus.stt[1] = 1'b0;
        step(3);
        bus.stt[1] = 1'b1;
        step(1);
        total++;
        if (bus.flag[1] !== 1'b1) begin bad++; $display("FAIL prehigh_t2p1: got %b want 1", bus.flag[1]); end
        step(1);
        total++;
        if (bus.flag[1] !== 1'b0) begin bad++; $display("FAIL prehigh_turn: got %b want 0", bus.flag[1]); end
        bus.stt[1] = 1'b0;
    endtask

    task automatic test_en_drop();
        restart();
        step(50);
        total++;
        if (bus.active !== 3'b011) begin bad++; $display("FAIL endrop_pre: got %b want 011", bus.active); end
        bus.en = 1'b0;
        step(1);
        total++;
        if (bus.active !== 3'b000 || bus.flag !== 3'b000) begin
            bad++; $display("FAIL endrop_clear: got act=%b flag=%b want 000 000", bus.active, bus.flag);
        end
        step(3);
        bus.en = 1'b1;
        step(2);
        total++;
        if (bus.active !== 3'b001 || bus.flag !== 3'b001) begin
            bad++; $display("FAIL endrop_relaunch: got act=%b flag=%b want 001 001", bus.active, bus.flag);
        end
        step(41);
        total++;
        if (bus.active !== 3'b011) begin bad++; $display("FAIL endrop_second: got %b want 011", bus.active); end
    endtask

    task automatic test_reset_mid_down();
        restart();
        step(5);
        bus.stt[0] = 1'b1;
        step(2);
        bus.stt[0] = 1'b0;
        step(10);
        total++;
        if (bus.flag[0] !== 1'b0 || bus.active[0] !== 1'b1) begin
            bad++; $display("FAIL middown_pre: got flag=%b act=%b want 0 1", bus.flag[0], bus.active[0]);
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (bus.flag !== 3'b000 || bus.active !== 3'b000 || bus.err !== 3'b000) begin
            bad++; $display("FAIL middown_async: got flag=%b act=%b err=%b want 000", bus.flag, bus.active, bus.err);
        end
        step(1);
        RST = 1'b0;
    endtask

    task automatic test_top_timeout();
        bus.stt = 3'b000;
        restart();
        step(73);
        total++;
        if (bus.flag[0] !== 1'b1 || bus.err[0] !== 1'b0) begin
            bad++; $display("FAIL timeout_t73: got flag=%b err=%b want 1 0", bus.flag[0], bus.err[0]);
        end
        step(1);
`ifdef RAINBOW_TOP_TIMEOUT_EN
        total++;
        if (bus.flag[0] !== 1'b0 || bus.err[0] !== 1'b1) begin
            bad++; $display("FAIL timeout_fire: got flag=%b err=%b want 0 1", bus.flag[0], bus.err[0]);
        end
        restart();
        step(2);
        total++;
        if (bus.err[0] !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", bus.err[0]); end
        RST = 1'b1;
        #1;
        total++;
        if (bus.err !== 3'b000) begin bad++; $display("FAIL timeout_rst: got %b want 000", bus.err); end
        step(1);
        RST = 1'b0;
`else
        total++;
        if (bus.flag[0] !== 1'b1 || bus.err !== 3'b000) begin
            bad++; $display("FAIL no_timeout: got flag=%b err=%b want 1 000", bus.flag[0], bus.err);
        end
`endif
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.stt = 3'b000;
        test_reset();
        test_launch_stagger();
        test_ramp_turn();
        test_prehigh();
        test_en_drop();
        test_reset_mid_down();
        test_top_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rainbow_seq_ctrl.md
Name: rainbow_seq_ctrl

Overview:
Sequencer for three breathing PWM channels (R, G, B). Each channel's PWM ramps duty up or down according to its FLAG and raises STT while at top of ramp. This block drives the three FLAG inputs so each channel runs a clean up/down triangle with no wrap-around. It launches the channels staggered by one third of a triangle to produce a rainbow hue sweep. Sits between top-level enable and the three PWM instances.

Parameters:
FREQ, 2400, PWM period in clocks; must equal the freq of the driven PWM instances.
STAGGER_CLKS, 3840000, clocks between launching consecutive channels (default = 2*FREQ*FREQ/3).
CW, 25, width of internal clock-count timers.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
EN  in  1  run enable; level-sensitive
STT  in  3  top-of-ramp monitor from PWM channels [0]=R [1]=G [2]=B; high for a whole PWM period
FLAG  out  3  ramp direction to each PWM channel; 1=up, 0=down
ACTIVE  out  3  channel k launched and running
ERR  out  3  sticky top-timeout flag per channel; constant 0 unless RAINBOW_TOP_TIMEOUT_EN

Behaviour:
- Reset (async, RST=1): FLAG=0, ACTIVE=0, ERR=0, sequencer IDLE, all channels OFF, timers 0, STT edge regs 0.
- Localparam BOT_DLY = FREQ*(FREQ-1) + FREQ/2. Clocks from a top edge to the down-to-up flip: lands mid-period after the channel reaches 0 and before it would wrap.
- STT edge: per-channel registered copy stt_q; top edge = STT[k] & ~stt_q[k]. Only rising edges count.
- Per-channel FSM (OFF, UP, DOWN):
  - OFF: FLAG[k]=0, ACTIVE[k]=0. On launch -> UP. Load stt_q[k] with current STT[k] so an already-high STT is not an edge.
  - UP: FLAG[k]=1. On top edge -> DOWN, timer=0. FLAG falls the cycle after the edge is detected, i.e. 2 clocks after STT rises.
  - DOWN: FLAG[k]=0, timer increments each clock. At timer==BOT_DLY-1 -> UP next cycle. A top edge in DOWN is ignored.
- Sequencer FSM (IDLE, LAUNCH, GAP, RUN), index k from 0 to 2:
  - IDLE: on EN=1 -> LAUNCH with k=0.
  - LAUNCH: pulses launch to channel k for 1 clock.
    - If k==2 -> RUN.
    - Otherwise -> GAP, gap timer=0.
  - GAP: gap timer increments. At STAGGER_CLKS-1 -> LAUNCH with k+1.
  - RUN: holds.
- EN=0 in any state: next clock sequencer -> IDLE, all channels -> OFF, timers cleared. ERR is not cleared (RST only).
- EN re-asserted: full restart from channel 0.
- Launch and top edge never coincide for one channel: a channel is OFF at launch.
- STAGGER_CLKS=0 is illegal. STAGGER_CLKS=1 launches on consecutive LAUNCH/GAP pairs.
- Timer widths: CW bits; FREQ*FREQ must be < 2**CW (checked by elaboration assertion).

Optional Feature:
RAINBOW_TOP_TIMEOUT_EN
- Defined: in UP, a per-channel timer counts clocks since entering UP. If it reaches FREQ*FREQ + FREQ without a top edge, then:
  - ERR[k] sets (sticky until RST);
  - the channel is forced to DOWN with timer=0, as if a top edge occurred.
- Not defined: no UP timer logic. ERR tied to 0. UP waits indefinitely for STT.

Decomposition:
- Package rainbow_pkg:
  - channel state enum (OFF, UP, DOWN);
  - sequencer state enum (IDLE, LAUNCH, GAP, RUN);
  - default FREQ, CW;
  - channel index constants R=0, G=1, B=2.
- One sub-module rainbow_ch_fsm, instantiated 3x. It holds the channel FSM, edge detect, DOWN timer and optional UP timeout.
  - Inputs: CLK, RST, EN, launch, stt.
  - Outputs: flag, active, err.
- rainbow_seq_ctrl holds the sequencer and gap timer.

Test Plan:
All tests use FREQ=8 (BOT_DLY=60) and STAGGER_CLKS=40.
1. Reset: assert RST mid-DOWN -> FLAG=000, ACTIVE=000, ERR=000 immediately, no clock needed.
2. Launch stagger: EN=1 at t0 -> ACTIVE[0] at t0+2, ACTIVE[1] 41 clocks later, ACTIVE[2] another 41 later; FLAG rises with each ACTIVE.
3. Ramp turn: channel 0 in UP, STT[0] rises at t1 -> FLAG[0]=0 at t1+2; FLAG[0] returns to 1 exactly 60 clocks after that. STT held high 8 clocks causes no second turn.
4. Pre-high STT: STT[1]=1 already when channel 1 launches -> stays UP. Next rise after a low period causes DOWN.
5. EN drop: EN=0 during GAP after channel 1 launch -> next clock ACTIVE=000, FLAG=000. EN=1 again -> channel 0 relaunches first.
6. RAINBOW_TOP_TIMEOUT_EN defined, STT held 0 -> 72 clocks after entering UP, ERR[k]=1 and FLAG[k]=0. ERR persists through EN toggling until RST.
